// File: rtl/bus_arb2_if.sv
// One request/response channel of the arbiter: a requester drives the request
// fields, the responder returns a one-cycle ready strobe with read data.
interface bus_arb2_if;
  logic [31:0] addr;
  logic [2:0]  size;
  logic        write;
  logic [31:0] wdata;
  logic        valid;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output addr, size, write, wdata, valid,
    input  ready, rdata
  );

  modport slave (
    input  addr, size, write, wdata, valid,
    output ready, rdata
  );
endinterface

// File: rtl/bus_arb2.sv
// Two-requester round-robin arbiter sharing one slave port. A watchdog
// force-completes granted transactions the slave never acknowledges.
module bus_arb2 #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic       clk,
  input  logic       rstb,
  bus_arb2_if.slave  m0,
  bus_arb2_if.slave  m1,
  bus_arb2_if.master s,
  output logic [1:0] grant,
  output logic       timeout_err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  // Watchdog value seen on the TIMEOUT-th granted cycle.
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 32'd1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic        last_r;
  logic        last_nxt_s;
  logic [15:0] wdog_r;
  logic [15:0] wdog_nxt_s;
  logic        req_valid_s;
  logic        expire_s;

  // state, round-robin pointer and watchdog registers
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      wdog_r  <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      last_r  <= last_nxt_s;
      wdog_r  <= wdog_nxt_s;
    end
  end

  // owner's request and watchdog expiry; slave completion beats expiry
  always_comb begin
    req_valid_s = 1'b0;
    case (state_r)
      GNT0:    req_valid_s = m0.valid;
      GNT1:    req_valid_s = m1.valid;
      default: req_valid_s = 1'b0;
    endcase
    expire_s = req_valid_s & ~s.ready & (wdog_r == WDOG_LAST);
  end

  // next-state: arbitration in IDLE, completion/expiry/abort while granted
  always_comb begin
    state_nxt_s = state_r;
    last_nxt_s  = last_r;
    wdog_nxt_s  = wdog_r;
    case (state_r)
      IDLE: begin
        wdog_nxt_s = 16'd0;
        if (m0.valid && m1.valid) begin
          state_nxt_s = last_r ? GNT0 : GNT1;
        end else if (m0.valid) begin
          state_nxt_s = GNT0;
        end else if (m1.valid) begin
          state_nxt_s = GNT1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GNT0, GNT1: begin
        if (!req_valid_s) begin
          // requester withdrew: drop the grant, fairness pointer untouched
          state_nxt_s = IDLE;
          wdog_nxt_s  = 16'd0;
        end else if (s.ready || expire_s) begin
          state_nxt_s = IDLE;
          last_nxt_s  = (state_r == GNT1);
          wdog_nxt_s  = 16'd0;
        end else begin
          wdog_nxt_s  = wdog_r + 16'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        wdog_nxt_s  = 16'd0;
      end
    endcase
  end

  // request mux to the slave, response demux back to the owner
  always_comb begin
    s.addr      = m0.addr;
    s.size      = m0.size;
    s.write     = m0.write;
    s.wdata     = m0.wdata;
    s.valid     = 1'b0;
    m0.ready    = 1'b0;
    m0.rdata    = 32'd0;
    m1.ready    = 1'b0;
    m1.rdata    = 32'd0;
    grant       = 2'b00;
    timeout_err = 1'b0;
    case (state_r)
      GNT0: begin
        s.valid     = m0.valid;
        m0.ready    = s.ready | expire_s;
        m0.rdata    = expire_s ? ERR_DATA : s.rdata;
        grant       = 2'b01;
        timeout_err = expire_s;
      end
      GNT1: begin
        s.addr      = m1.addr;
        s.size      = m1.size;
        s.write     = m1.write;
        s.wdata     = m1.wdata;
        s.valid     = m1.valid;
        m1.ready    = s.ready | expire_s;
        m1.rdata    = expire_s ? ERR_DATA : s.rdata;
        grant       = 2'b10;
        timeout_err = expire_s;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arb2.sv
// Self-checking bench for bus_arb2: per-requester scoreboards of expected
// completions, a latency-programmable slave model and grant-order tracking.
module tb_bus_arb2;
  localparam int unsigned TO   = 8;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;
  localparam logic [31:0] KEY  = 32'h5A5A_0000;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic [1:0] grant;
  logic       timeout_err;

  bus_arb2_if m0_bus ();
  bus_arb2_if m1_bus ();
  bus_arb2_if s_bus ();

  bus_arb2 #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .rstb(rstb), .m0(m0_bus), .m1(m1_bus), .s(s_bus),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // slave model: ready after slv_wait stalled cycles (never when negative)
  int          slv_wait = 0;
  int          slv_cnt;
  bit          slv_fix_en = 1'b0;
  logic [31:0] slv_fix = 32'd0;
  assign s_bus.ready = s_bus.valid && (slv_wait >= 0) && (slv_cnt == slv_wait);
  assign s_bus.rdata = slv_fix_en ? slv_fix : (s_bus.addr ^ KEY);

  always @(posedge clk or negedge rstb) begin
    if (!rstb) slv_cnt <= 0;
    else if (s_bus.valid && !s_bus.ready) slv_cnt <= slv_cnt + 1;
    else slv_cnt <= 0;
  end

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  int          m_left[2];
  int          m_idx[2];
  bit          pend[2];
  bit          rdy_seen[2];
  logic [31:0] m_addr[2];
  bit          exp_err = 1'b0;
  logic [1:0]  prev_grant;
  bit          prev_rdy;
  int          gcnt, idle_len, rdy_gcnt, terr_cnt;
  int          rdy_cnt[2];
  logic [1:0]  gseq[$];
  int          gaps[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int i, input int idx);
    return ((i == 0) ? 32'h0000_1000 : 32'h0000_8000) + 32'(idx * 4);
  endfunction

  // apply master bookkeeping after an edge; push expectations for new requests
  task automatic drive_masters();
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      logic v;
      if (rdy_seen[i]) begin
        rdy_seen[i] = 1'b0;
        pend[i] = 1'b0;
        if (m_left[i] > 0) m_left[i]--;
        m_idx[i]++;
      end
      m_addr[i] = addr_of(i, m_idx[i]);
      v = (m_left[i] > 0);
      if (v && !pend[i]) begin
        pend[i] = 1'b1;
        e.data = exp_err ? ERRD : (slv_fix_en ? slv_fix : (m_addr[i] ^ KEY));
        e.err  = exp_err;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      if (i == 0) begin
        m0_bus.addr = m_addr[0]; m0_bus.size = 3'(m_idx[0]);
        m0_bus.write = 1'(m_idx[0] & 1); m0_bus.wdata = ~m_addr[0]; m0_bus.valid = v;
      end else begin
        m1_bus.addr = m_addr[1]; m1_bus.size = 3'(m_idx[1]);
        m1_bus.write = 1'(m_idx[1] & 1); m1_bus.wdata = ~m_addr[1]; m1_bus.valid = v;
      end
    end
  endtask

  // sample outputs mid-cycle and retire completions against the scoreboards
  task automatic observe();
    exp_t e;
    if (prev_rdy) check_val("bubble", 32'(grant), 32'd0);
    if (grant == 2'b00) begin
      check_val("idle s_valid", 32'(s_bus.valid), 32'd0);
      idle_len++;
      gcnt = 0;
    end else begin
      if (prev_grant == 2'b00) begin
        gseq.push_back(grant);
        gaps.push_back(idle_len);
        idle_len = 0;
      end
      gcnt++;
    end
    if (grant == 2'b01) begin
      check_val("s_addr m0", s_bus.addr, m_addr[0]);
      check_val("s_wdata m0", s_bus.wdata, ~m_addr[0]);
    end
    if (grant == 2'b10) begin
      check_val("s_addr m1", s_bus.addr, m_addr[1]);
      check_val("s_ctl m1", 32'({s_bus.write, s_bus.size}), 32'({1'(m_idx[1] & 1), 3'(m_idx[1])}));
    end
    if (m0_bus.ready && m1_bus.ready) check_val("dual ready", 32'd1, 32'd0);
    if (m0_bus.ready) begin
      rdy_cnt[0]++; rdy_seen[0] = 1'b1; rdy_gcnt = gcnt;
      check_val("m1 rdata quiet", m1_bus.rdata, 32'd0);
      if (q0.size() == 0) check_val("q0 underflow", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        check_val("m0 rdata", m0_bus.rdata, e.data);
        check_val("m0 timeout_err", 32'(timeout_err), 32'(e.err));
      end
    end
    if (m1_bus.ready) begin
      rdy_cnt[1]++; rdy_seen[1] = 1'b1; rdy_gcnt = gcnt;
      check_val("m0 rdata quiet", m0_bus.rdata, 32'd0);
      if (q1.size() == 0) check_val("q1 underflow", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        check_val("m1 rdata", m1_bus.rdata, e.data);
        check_val("m1 timeout_err", 32'(timeout_err), 32'(e.err));
      end
    end
    if (timeout_err) terr_cnt++;
    prev_rdy = m0_bus.ready | m1_bus.ready;
    prev_grant = grant;
  endtask

  task automatic step();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    drive_masters();
  endtask

  task automatic run(input int max_steps);
    int n = 0;
    while ((m_left[0] > 0 || m_left[1] > 0) && n < max_steps) begin
      step();
      n++;
    end
    check_val("run bound", 32'(m_left[0] + m_left[1]), 32'd0);
    step();
  endtask

  task automatic clear_track();
    prev_grant = 2'b00; prev_rdy = 1'b0;
    gcnt = 0; idle_len = 0; rdy_gcnt = 0; terr_cnt = 0;
    rdy_cnt[0] = 0; rdy_cnt[1] = 0;
    gseq.delete(); gaps.delete();
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_left[i] = 0; pend[i] = 1'b0; rdy_seen[i] = 1'b0;
    end
    q0.delete(); q1.delete();
    clear_track();
    drive_masters();
    @(posedge clk);
    #1;
    check_val("rst grant", 32'(grant), 32'd0);
    check_val("rst s_valid", 32'(s_bus.valid), 32'd0);
    check_val("rst readies", 32'({m0_bus.ready, m1_bus.ready}), 32'd0);
    check_val("rst timeout_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_idx[0] = 0; m_idx[1] = 0;
    do_reset();

    // single m0 read, slave answers on the third granted cycle
    slv_wait = 2; slv_fix_en = 1'b1; slv_fix = 32'h12345678;
    m_left[0] = 1; drive_masters();
    step();
    check_val("t1 grant latency", 32'(grant), 32'd1);
    run(20);
    check_val("t1 ready cycle", 32'(rdy_gcnt), 32'd3);
    check_val("t1 m0 readies", 32'(rdy_cnt[0]), 32'd1);
    check_val("t1 m1 readies", 32'(rdy_cnt[1]), 32'd0);

    // both held valid from reset, zero-wait slave: strict alternation
    do_reset();
    slv_wait = 0; slv_fix_en = 1'b0;
    m_left[0] = 3; m_left[1] = 3; drive_masters();
    run(60);
    check_val("t2 grants", 32'(gseq.size()), 32'd6);
    for (int i = 0; i < gseq.size(); i++) begin
      check_val("t2 order", 32'(gseq[i]), ((i % 2) == 0) ? 32'd1 : 32'd2);
      if (i > 0) check_val("t2 gap", 32'(gaps[i]), 32'd1);
    end

    // m1 owns the bus when m0 arrives: no preemption, one bubble
    clear_track();
    slv_wait = 3;
    m_left[1] = 1; drive_masters();
    for (int n = 0; n < 10 && grant != 2'b10; n++) step();
    check_val("t3 m1 grant", 32'(grant), 32'd2);
    m_left[0] = 1; drive_masters();
    run(40);
    check_val("t3 grants", 32'(gseq.size()), 32'd2);
    if (gseq.size() == 2) begin
      check_val("t3 first", 32'(gseq[0]), 32'd2);
      check_val("t3 second", 32'(gseq[1]), 32'd1);
      check_val("t3 gap", 32'(gaps[1]), 32'd1);
    end

    // dead slave: forced completion on the 8th granted cycle
    clear_track();
    slv_wait = -1; exp_err = 1'b1;
    m_left[0] = 1; drive_masters();
    run(30);
    exp_err = 1'b0;
    check_val("t4 ready cycle", 32'(rdy_gcnt), 32'd8);
    check_val("t4 err pulses", 32'(terr_cnt), 32'd1);
    check_val("t4 idle", 32'(grant), 32'd0);

    // slave answers on exactly the expiry cycle: normal completion wins
    clear_track();
    slv_wait = 7; slv_fix_en = 1'b1; slv_fix = 32'hA5A5A5A5;
    m_left[0] = 1; drive_masters();
    run(30);
    check_val("t5 ready cycle", 32'(rdy_gcnt), 32'd8);
    check_val("t5 err pulses", 32'(terr_cnt), 32'd0);

    // requester withdraws mid-transaction: quiet return to idle
    clear_track();
    slv_wait = -1; slv_fix_en = 1'b0;
    m_left[0] = 1; drive_masters();
    step(); step(); step();
    m_left[0] = 0; pend[0] = 1'b0; q0.delete(); drive_masters();
    step();
    check_val("t6 idle", 32'(grant), 32'd0);
    step();
    check_val("t6 no ready", 32'(rdy_cnt[0] + rdy_cnt[1]), 32'd0);
    check_val("t6 no err", 32'(terr_cnt), 32'd0);

    // async reset while m1 is stalled, then m0 wins the first tie
    clear_track();
    m_left[1] = 1; drive_masters();
    step(); step();
    check_val("t7 m1 grant", 32'(grant), 32'd2);
    m_left[0] = 1; drive_masters();
    rstb = 1'b0;
    #1;
    check_val("t7 rst grant", 32'(grant), 32'd0);
    check_val("t7 rst s_valid", 32'(s_bus.valid), 32'd0);
    @(posedge clk);
    #1;
    rstb = 1'b1;
    clear_track();
    slv_wait = 0;
    run(30);
    check_val("t7 grants", 32'(gseq.size()), 32'd2);
    if (gseq.size() == 2) begin
      check_val("t7 first", 32'(gseq[0]), 32'd1);
      check_val("t7 second", 32'(gseq[1]), 32'd2);
    end

    check_val("q0 drained", 32'(q0.size()), 32'd0);
    check_val("q1 drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
